// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared opcode, state and control-field encodings for the multicycle MIPS controller
package mips_ctrl_pkg;

    localparam int OPW_DEFAULT = 6;

    // Supported instruction opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // Controller states
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BEQ    = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11,
        S_ERROR  = 4'd12
    } state_t;

    // ALU operation select
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // ALU B operand select
    localparam logic [1:0] SRCB_RT      = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    // States that own the memory port and wait on mem_ready
    function automatic logic is_mem_state(input logic [3:0] s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/ctrl_out_decode.sv
// rtl/ctrl_out_decode.sv - combinational state(+mem_ready) to control-word table
module ctrl_out_decode
    import mips_ctrl_pkg::*;
(
    input  logic [3:0] i_state,
    input  logic       i_mem_ready,
    output logic       o_iord,
    output logic       o_irwrite,
    output logic       o_pcwrite,
    output logic       o_branch,
    output logic [1:0] o_pcsrc,
    output logic       o_alusrca,
    output logic [1:0] o_alusrcb,
    output logic [1:0] o_aluop,
    output logic       o_regwrite,
    output logic       o_memwrite,
    output logic       o_regdst,
    output logic       o_memtoreg,
    output logic       o_instr_done
);

    // Moore control table; only FETCH and MEMWR also look at mem_ready
    always_comb begin
        o_iord       = 1'b0;
        o_irwrite    = 1'b0;
        o_pcwrite    = 1'b0;
        o_branch     = 1'b0;
        o_pcsrc      = PCSRC_ALU;
        o_alusrca    = 1'b0;
        o_alusrcb    = SRCB_RT;
        o_aluop      = ALUOP_ADD;
        o_regwrite   = 1'b0;
        o_memwrite   = 1'b0;
        o_regdst     = 1'b0;
        o_memtoreg   = 1'b0;
        o_instr_done = 1'b0;
        case (state_t'(i_state))
            S_FETCH: begin
                o_alusrcb = SRCB_FOUR;
                o_irwrite = i_mem_ready;
                o_pcwrite = i_mem_ready;
            end
            S_DECODE: begin
                o_alusrcb = SRCB_IMM_SH2;
            end
            S_MEMADR: begin
                o_alusrca = 1'b1;
                o_alusrcb = SRCB_IMM;
            end
            S_MEMRD: begin
                o_iord = 1'b1;
            end
            S_MEMWB: begin
                o_memtoreg   = 1'b1;
                o_regwrite   = 1'b1;
                o_instr_done = 1'b1;
            end
            S_MEMWR: begin
                o_iord       = 1'b1;
                o_memwrite   = 1'b1;
                o_instr_done = i_mem_ready;
            end
            S_EXEC: begin
                o_alusrca = 1'b1;
                o_alusrcb = SRCB_RT;
                o_aluop   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                o_regdst     = 1'b1;
                o_regwrite   = 1'b1;
                o_instr_done = 1'b1;
            end
            S_BEQ: begin
                o_alusrca    = 1'b1;
                o_aluop      = ALUOP_SUB;
                o_pcsrc      = PCSRC_ALUOUT;
                o_branch     = 1'b1;
                o_instr_done = 1'b1;
            end
            S_ADDIEX: begin
                o_alusrca = 1'b1;
                o_alusrcb = SRCB_IMM;
            end
            S_ADDIWB: begin
                o_regwrite   = 1'b1;
                o_instr_done = 1'b1;
            end
            S_JUMP: begin
                o_pcsrc      = PCSRC_JUMP;
                o_pcwrite    = 1'b1;
                o_instr_done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - multicycle MIPS control FSM with memory-wait timeout
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int OPW        = 6,
    parameter int WAIT_LIMIT = 15
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [OPW-1:0] opcode,
    input  logic           mem_ready,
    output logic           IorD,
    output logic           IRWrite,
    output logic           PCWrite,
    output logic           Branch,
    output logic [1:0]     PCSrc,
    output logic           ALUSrcA,
    output logic [1:0]     ALUSrcB,
    output logic [1:0]     ALUOp,
    output logic           RegWrite,
    output logic           MemWrite,
    output logic           RegDst,
    output logic           MemtoReg,
    output logic           instr_done,
    output logic           illegal_op,
    output logic           fault
);

    state_t     r_state;
    state_t     w_state_next;
    logic [7:0] r_wait_cnt;
    logic       r_fault;
    logic       w_in_mem;
    logic       w_timeout;
    logic       w_op_legal;

    logic       w_irwrite;
    logic       w_pcwrite;
    logic       w_branch;
    logic       w_regwrite;
    logic       w_memwrite;

    assign w_in_mem   = is_mem_state(r_state);
    // The limit cycle only faults if the access still has not completed
    assign w_timeout  = w_in_mem && !mem_ready && (r_wait_cnt == 8'(WAIT_LIMIT - 1));
    assign w_op_legal = (opcode == OPW'(OP_RTYPE)) || (opcode == OPW'(OP_J))  ||
                        (opcode == OPW'(OP_BEQ))   || (opcode == OPW'(OP_ADDI)) ||
                        (opcode == OPW'(OP_LW))    || (opcode == OPW'(OP_SW));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Wait counter clears on every state change; fault is sticky until reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait_cnt <= 8'd0;
            r_fault    <= 1'b0;
        end else begin
            if (w_state_next != r_state) begin
                r_wait_cnt <= 8'd0;
            end else if (w_in_mem && !mem_ready) begin
                r_wait_cnt <= r_wait_cnt + 8'd1;
            end
            if (w_state_next == S_ERROR) begin
                r_fault <= 1'b1;
            end
        end
    end

    // Next-state sequencing; opcode is only consulted in DECODE and MEMADR
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_FETCH: begin
                if (mem_ready)      w_state_next = S_DECODE;
                else if (w_timeout) w_state_next = S_ERROR;
            end
            S_DECODE: begin
                if ((opcode == OPW'(OP_LW)) || (opcode == OPW'(OP_SW))) w_state_next = S_MEMADR;
                else if (opcode == OPW'(OP_RTYPE))                      w_state_next = S_EXEC;
                else if (opcode == OPW'(OP_BEQ))                        w_state_next = S_BEQ;
                else if (opcode == OPW'(OP_ADDI))                       w_state_next = S_ADDIEX;
                else if (opcode == OPW'(OP_J))                          w_state_next = S_JUMP;
                else                                                    w_state_next = S_FETCH;
            end
            S_MEMADR: begin
                w_state_next = (opcode == OPW'(OP_SW)) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                if (mem_ready)      w_state_next = S_MEMWB;
                else if (w_timeout) w_state_next = S_ERROR;
            end
            S_MEMWR: begin
                if (mem_ready)      w_state_next = S_FETCH;
                else if (w_timeout) w_state_next = S_ERROR;
            end
            S_EXEC:   w_state_next = S_ALUWB;
            S_ADDIEX: w_state_next = S_ADDIWB;
            S_MEMWB, S_ALUWB, S_BEQ, S_ADDIWB, S_JUMP: w_state_next = S_FETCH;
            S_ERROR:  w_state_next = S_ERROR;
            default:  w_state_next = S_FETCH;
        endcase
    end

    ctrl_out_decode u_decode (
        .i_state      (r_state),
        .i_mem_ready  (mem_ready),
        .o_iord       (IorD),
        .o_irwrite    (w_irwrite),
        .o_pcwrite    (w_pcwrite),
        .o_branch     (w_branch),
        .o_pcsrc      (PCSrc),
        .o_alusrca    (ALUSrcA),
        .o_alusrcb    (ALUSrcB),
        .o_aluop      (ALUOp),
        .o_regwrite   (w_regwrite),
        .o_memwrite   (w_memwrite),
        .o_regdst     (RegDst),
        .o_memtoreg   (MemtoReg),
        .o_instr_done (instr_done)
    );

    // Write enables are suppressed during reset so an abandoned instruction has no side effects
    always_comb begin
        IRWrite    = w_irwrite  && !rst;
        PCWrite    = w_pcwrite  && !rst;
        Branch     = w_branch   && !rst;
        RegWrite   = w_regwrite && !rst;
        MemWrite   = w_memwrite && !rst;
        illegal_op = (r_state == S_DECODE) && !w_op_legal;
        fault      = r_fault;
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb/tb_mips_multicycle_ctrl.sv - self-checking bench for mips_multicycle_ctrl
module tb_mips_multicycle_ctrl;

    localparam int WL = 15;

    localparam logic [5:0] C_R    = 6'b000000;
    localparam logic [5:0] C_J    = 6'b000010;
    localparam logic [5:0] C_BEQ  = 6'b000100;
    localparam logic [5:0] C_ADDI = 6'b001000;
    localparam logic [5:0] C_LW   = 6'b100011;
    localparam logic [5:0] C_SW   = 6'b101011;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       IorD, IRWrite, PCWrite, Branch, ALUSrcA;
    logic [1:0] PCSrc, ALUSrcB, ALUOp;
    logic       RegWrite, MemWrite, RegDst, MemtoReg, instr_done, illegal_op, fault;

    always #5 clk = ~clk;

    mips_multicycle_ctrl #(.OPW(6), .WAIT_LIMIT(WL)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .IorD(IorD), .IRWrite(IRWrite), .PCWrite(PCWrite), .Branch(Branch),
        .PCSrc(PCSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .RegWrite(RegWrite), .MemWrite(MemWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
        .instr_done(instr_done), .illegal_op(illegal_op), .fault(fault)
    );

    logic [17:0] dut_word;
    assign dut_word = {IorD, IRWrite, PCWrite, Branch, PCSrc, ALUSrcA, ALUSrcB, ALUOp,
                       RegWrite, MemWrite, RegDst, MemtoReg, instr_done, illegal_op, fault};

    int n_checks = 0;
    int n_errors = 0;

    // Instruction-step model: each opcode expands into a list of remaining steps
    typedef enum int {K_FETCH, K_DECODE, K_MEMADR, K_MEMRD, K_MEMWB, K_MEMWR, K_EXEC,
                      K_ALUWB, K_BEQ, K_ADDIEX, K_ADDIWB, K_JUMP, K_ERROR} kind_t;
    kind_t m_cur = K_FETCH;
    kind_t m_q[$];
    int    m_wait = 0;

    // Observation counters for directed literal checks
    int cyc_idx, first_done, cnt_done, cnt_regw, cnt_memw, cnt_pcw, cnt_br, cnt_ill, cnt_fault;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (model step %s)", name, act, exp, m_cur.name());
        end
    endtask

    function automatic bit op_legal(input logic [5:0] op);
        return op inside {C_R, C_J, C_BEQ, C_ADDI, C_LW, C_SW};
    endfunction

    function automatic logic [17:0] model_word(input kind_t k, input logic rdy, input logic r,
                                               input logic [5:0] op);
        logic iord, irw, pcw, br, srca, rw, mw, rd, m2r, done, ill, flt;
        logic [1:0] pcs, srcb, aop;
        iord = 0; irw = 0; pcw = 0; br = 0; srca = 0; rw = 0; mw = 0; rd = 0;
        m2r = 0; done = 0; ill = 0; flt = 0; pcs = 2'b00; srcb = 2'b00; aop = 2'b00;
        case (k)
            K_FETCH:  begin srcb = 2'b01; irw = rdy; pcw = rdy; end
            K_DECODE: begin srcb = 2'b11; ill = !op_legal(op); end
            K_MEMADR: begin srca = 1; srcb = 2'b10; end
            K_MEMRD:  begin iord = 1; end
            K_MEMWB:  begin m2r = 1; rw = 1; done = 1; end
            K_MEMWR:  begin iord = 1; mw = 1; done = rdy; end
            K_EXEC:   begin srca = 1; srcb = 2'b00; aop = 2'b10; end
            K_ALUWB:  begin rd = 1; rw = 1; done = 1; end
            K_BEQ:    begin srca = 1; aop = 2'b01; pcs = 2'b01; br = 1; done = 1; end
            K_ADDIEX: begin srca = 1; srcb = 2'b10; end
            K_ADDIWB: begin rw = 1; done = 1; end
            K_JUMP:   begin pcs = 2'b10; pcw = 1; done = 1; end
            default:  begin flt = 1; end
        endcase
        if (r) begin irw = 0; pcw = 0; br = 0; rw = 0; mw = 0; end
        return {iord, irw, pcw, br, pcs, srca, srcb, aop, rw, mw, rd, m2r, done, ill, flt};
    endfunction

    task automatic model_step(input logic r, input logic [5:0] op, input logic rdy);
        if (r) begin
            m_cur = K_FETCH; m_q.delete(); m_wait = 0;
        end else if (m_cur == K_ERROR) begin
            m_cur = K_ERROR;
        end else if ((m_cur inside {K_FETCH, K_MEMRD, K_MEMWR}) && !rdy) begin
            m_wait++;
            if (m_wait == WL) begin m_cur = K_ERROR; m_wait = 0; end
        end else begin
            m_wait = 0;
            if (m_cur == K_FETCH) begin
                m_cur = K_DECODE;
            end else begin
                if (m_cur == K_DECODE) begin
                    case (op)
                        C_LW:    m_q = '{K_MEMADR, K_MEMRD, K_MEMWB};
                        C_SW:    m_q = '{K_MEMADR, K_MEMWR};
                        C_R:     m_q = '{K_EXEC, K_ALUWB};
                        C_BEQ:   m_q = '{K_BEQ};
                        C_ADDI:  m_q = '{K_ADDIEX, K_ADDIWB};
                        C_J:     m_q = '{K_JUMP};
                        default: m_q.delete();
                    endcase
                end
                if (m_q.size() == 0) m_cur = K_FETCH;
                else                 m_cur = m_q.pop_front();
            end
        end
    endtask

    task automatic clr();
        cyc_idx = 0; first_done = 0; cnt_done = 0; cnt_regw = 0; cnt_memw = 0;
        cnt_pcw = 0; cnt_br = 0; cnt_ill = 0; cnt_fault = 0;
    endtask

    // One clock: drive on the falling edge, compare 1 time unit later, then advance the model
    task automatic cycle(input logic r, input logic [5:0] op, input logic rdy, input bit do_chk);
        @(negedge clk);
        rst = r; opcode = op; mem_ready = rdy;
        #1;
        if (do_chk) chk("ctrl_word", {14'd0, dut_word}, {14'd0, model_word(m_cur, rdy, r, op)});
        cyc_idx++;
        if (instr_done && first_done == 0) first_done = cyc_idx;
        cnt_done  += int'(instr_done);
        cnt_regw  += int'(RegWrite);
        cnt_memw  += int'(MemWrite);
        cnt_pcw   += int'(PCWrite);
        cnt_br    += int'(Branch);
        cnt_ill   += int'(illegal_op);
        cnt_fault += int'(fault);
        model_step(r, op, rdy);
    endtask

    initial begin
        logic [5:0] op_sel;
        logic [5:0] ops [6];
        logic       r, rdy;
        ops[0] = C_R; ops[1] = C_J; ops[2] = C_BEQ; ops[3] = C_ADDI; ops[4] = C_LW; ops[5] = C_SW;

        // Reset: the first cycle precedes any reset edge, so it is not compared
        cycle(1, C_R, 1, 0);
        cycle(1, C_R, 1, 1);
        chk("reset_fault", {31'd0, fault}, 32'd0);
        chk("reset_irwrite", {31'd0, IRWrite}, 32'd0);

        // lw with memory always ready: 5 cycles, single writeback
        clr();
        repeat (5) cycle(0, C_LW, 1, 1);
        chk("lw_latency", first_done, 5);
        chk("lw_done_count", cnt_done, 1);
        chk("lw_regwrite_count", cnt_regw, 1);

        // sw with 3 wait cycles in MEMWR: 7 cycles, MemWrite held 4
        clr();
        cycle(0, C_SW, 1, 1); cycle(0, C_SW, 1, 1); cycle(0, C_SW, 1, 1);
        cycle(0, C_SW, 0, 1); cycle(0, C_SW, 0, 1); cycle(0, C_SW, 0, 1);
        cycle(0, C_SW, 1, 1);
        chk("sw_latency", first_done, 7);
        chk("sw_memwrite_count", cnt_memw, 4);

        // beq then j: 3 + 3 cycles
        clr();
        repeat (3) cycle(0, C_BEQ, 1, 1);
        chk("beq_branch_count", cnt_br, 1);
        chk("beq_latency", first_done, 3);
        repeat (3) cycle(0, C_J, 1, 1);
        chk("beq_j_done_count", cnt_done, 2);
        chk("beq_j_pcwrite_count", cnt_pcw, 3);

        // Unsupported opcode traps in DECODE and returns to FETCH
        clr();
        cycle(0, 6'b111111, 1, 1); cycle(0, 6'b111111, 1, 1); cycle(0, 6'b111111, 1, 1);
        chk("illegal_pulse_count", cnt_ill, 1);
        chk("illegal_no_writes", cnt_regw + cnt_memw + cnt_br + cnt_done, 0);

        // Memory hang in FETCH: 15 wait cycles then sticky fault
        cycle(1, C_R, 0, 1);
        clr();
        repeat (WL) cycle(0, C_R, 0, 1);
        chk("fault_before_limit", cnt_fault, 0);
        repeat (4) cycle(0, C_R, 1, 1);
        chk("fault_sticky", cnt_fault, 4);
        cycle(1, C_R, 1, 1);
        cycle(0, C_R, 1, 1);
        chk("fault_cleared", {31'd0, fault}, 32'd0);

        // Limit cycle with mem_ready=1 completes without fault
        cycle(1, C_R, 0, 1);
        clr();
        repeat (WL - 1) cycle(0, C_ADDI, 0, 1);
        repeat (4) cycle(0, C_ADDI, 1, 1);
        chk("limit_ready_wins", cnt_fault, 0);
        chk("limit_addi_done", cnt_done, 1);

        // Reset in ALUWB suppresses RegWrite; next R-type takes 4 cycles
        cycle(1, C_R, 1, 1);
        clr();
        repeat (3) cycle(0, C_R, 1, 1);
        cycle(1, C_R, 1, 1);
        chk("rst_aluwb_regwrite", cnt_regw, 0);
        clr();
        repeat (4) cycle(0, C_R, 1, 1);
        chk("r_after_rst_latency", first_done, 4);

        // Random traffic: mostly-ready memory, then slow memory that exercises timeouts
        op_sel = C_R;
        for (int i = 0; i < 3000; i++) begin
            if (m_cur == K_FETCH) begin
                if ($urandom_range(0, 7) == 0) op_sel = 6'($urandom);
                else                           op_sel = ops[$urandom_range(0, 5)];
            end
            if (i < 2000) begin
                rdy = ($urandom_range(0, 3) != 0);
                r   = ($urandom_range(0, 99) == 0);
            end else begin
                rdy = ($urandom_range(0, 7) != 0);
                r   = ($urandom_range(0, 29) == 0);
            end
            cycle(r, op_sel, rdy, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
